// File: rtl/mem_instr_sequencer.sv
// Instruction sequencer: fetches ROM words, issues read/shift commands, stalls on wfi, rewinds on loop.
// Optional macro MEM_SEQ_PERF_CNT_EN builds the STALL_CYCLES performance counter.
module mem_instr_sequencer #(
  parameter int INSTR_WIDTH = 56,
  parameter int ADDR_WIDTH  = 6,
  parameter int MASK_WIDTH  = 4,
  parameter int SHIFT_WIDTH = 4,
  parameter int ITER_WIDTH  = 16
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   START,
  input  logic [ITER_WIDTH-1:0]  NUM_ITER,
  output logic [ADDR_WIDTH-1:0]  ROM_ADDRESS,
  output logic                   ROM_ENABLE,
  input  logic [INSTR_WIDTH-1:0] ROM_DATA,
  output logic                   RD_VALID,
  output logic [MASK_WIDTH-1:0]  RD_MASK,
  input  logic                   RD_READY,
  output logic                   SH_VALID,
  output logic [SHIFT_WIDTH-1:0] SH_AMOUNT,
  output logic [INSTR_WIDTH-9:0] SH_LANE_SEL,
  input  logic                   SH_READY,
  input  logic                   WFI_RELEASE,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [ITER_WIDTH-1:0]  ITER_COUNT,
  output logic                   ERR_ILLEGAL,
  output logic [31:0]            STALL_CYCLES
);

  localparam logic [3:0] OP_READ  = 4'b0000;
  localparam logic [3:0] OP_SHIFT = 4'b0101;
  localparam logic [3:0] OP_WFI   = 4'b0110;
  localparam logic [3:0] OP_LOOP  = 4'b0111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE_RD, S_ISSUE_SH, S_WFI, S_LOOP
  } state_t;

  state_t state, next_state;

  logic [ADDR_WIDTH-1:0]  pc, pc_next, pc_inc;
  logic [ITER_WIDTH-1:0]  num_iter, num_iter_next;
  logic [ITER_WIDTH-1:0]  iter_count, iter_next, iter_inc;
  logic                   err, err_next;
  logic                   rd_valid, rd_valid_next;
  logic [MASK_WIDTH-1:0]  rd_mask, rd_mask_next;
  logic                   sh_valid, sh_valid_next;
  logic [SHIFT_WIDTH-1:0] sh_amount, sh_amount_next;
  logic [INSTR_WIDTH-9:0] sh_lane, sh_lane_next;
  logic                   rom_enable, rom_enable_next;
  logic                   busy, busy_next;
  logic                   done, done_next;
  logic [3:0]             opcode;
  logic                   last_iter;
  logic                   accept_start;

  assign opcode       = ROM_DATA[7:4];
  assign pc_inc       = pc + ADDR_WIDTH'(1);
  assign iter_inc     = iter_count + ITER_WIDTH'(1);
  assign last_iter    = (num_iter != '0) && (iter_inc == num_iter);
  // DONE cycle is already IDLE, so a coincident START must be rejected here.
  assign accept_start = (state == S_IDLE) && START && !done;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state      <= S_IDLE;
      pc         <= '0;
      num_iter   <= '0;
      iter_count <= '0;
      err        <= 1'b0;
      rd_valid   <= 1'b0;
      rd_mask    <= '0;
      sh_valid   <= 1'b0;
      sh_amount  <= '0;
      sh_lane    <= '0;
      rom_enable <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= next_state;
      pc         <= pc_next;
      num_iter   <= num_iter_next;
      iter_count <= iter_next;
      err        <= err_next;
      rd_valid   <= rd_valid_next;
      rd_mask    <= rd_mask_next;
      sh_valid   <= sh_valid_next;
      sh_amount  <= sh_amount_next;
      sh_lane    <= sh_lane_next;
      rom_enable <= rom_enable_next;
      busy       <= busy_next;
      done       <= done_next;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (accept_start) next_state = S_FETCH;
      S_FETCH:    next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_READ:  next_state = S_ISSUE_RD;
          OP_SHIFT: next_state = S_ISSUE_SH;
          OP_WFI:   next_state = S_WFI;
          OP_LOOP:  next_state = S_LOOP;
          default:  next_state = S_FETCH;
        endcase
      end
      S_ISSUE_RD: if (RD_READY) next_state = S_FETCH;
      S_ISSUE_SH: if (SH_READY) next_state = S_FETCH;
      S_WFI:      if (WFI_RELEASE) next_state = S_FETCH;
      S_LOOP:     next_state = last_iter ? S_IDLE : S_FETCH;
      default:    next_state = S_IDLE;
    endcase
  end

  // Every output is a register; this block computes their next values from next_state.
  always_comb begin
    pc_next        = pc;
    num_iter_next  = num_iter;
    iter_next      = iter_count;
    err_next       = err;
    rd_mask_next   = rd_mask;
    sh_amount_next = sh_amount;
    sh_lane_next   = sh_lane;
    case (state)
      S_IDLE: begin
        if (accept_start) begin
          pc_next       = '0;
          num_iter_next = NUM_ITER;
          iter_next     = '0;
          err_next      = 1'b0;
        end
      end
      S_DECODE: begin
        if (opcode == OP_READ) rd_mask_next = ROM_DATA[MASK_WIDTH-1:0];
        if (opcode == OP_SHIFT) begin
          sh_amount_next = ROM_DATA[SHIFT_WIDTH-1:0];
          sh_lane_next   = ROM_DATA[INSTR_WIDTH-1:8];
        end
        if (next_state == S_FETCH) begin
          err_next = 1'b1;
          pc_next  = pc_inc;
        end
      end
      S_ISSUE_RD, S_ISSUE_SH, S_WFI: begin
        if (next_state == S_FETCH) pc_next = pc_inc;
      end
      S_LOOP: begin
        iter_next = iter_inc;
        if (!last_iter) pc_next = '0;
      end
      default: ;
    endcase
    rom_enable_next = (next_state == S_FETCH);
    rd_valid_next   = (next_state == S_ISSUE_RD);
    sh_valid_next   = (next_state == S_ISSUE_SH);
    done_next       = (state == S_LOOP) && last_iter;
    busy_next       = (next_state != S_IDLE) || done_next;
  end

  assign ROM_ADDRESS = pc;
  assign ROM_ENABLE  = rom_enable;
  assign RD_VALID    = rd_valid;
  assign RD_MASK     = rd_mask;
  assign SH_VALID    = sh_valid;
  assign SH_AMOUNT   = sh_amount;
  assign SH_LANE_SEL = sh_lane;
  assign BUSY        = busy;
  assign DONE        = done;
  assign ITER_COUNT  = iter_count;
  assign ERR_ILLEGAL = err;

`ifdef MEM_SEQ_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic        stalled;

  assign stalled = ((state == S_ISSUE_RD) && !RD_READY) ||
                   ((state == S_ISSUE_SH) && !SH_READY) ||
                   ((state == S_WFI) && !WFI_RELEASE);

  // Saturating stall counter, cleared by an accepted START.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      stall_cycles <= '0;
    end else if (accept_start) begin
      stall_cycles <= '0;
    end else if (stalled && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

  assign STALL_CYCLES = stall_cycles;
`else
  assign STALL_CYCLES = '0;
`endif

endmodule
